mips_multicycle_control: RTL

//  Multicycle MIPS control unit: drives every control input of Datapath from Op/Funct and ALU overflow.

---
 rtl/mips_multicycle_control.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore main-decoder FSM plus combinational ALU decoder.
// Optionally traps signed overflow on add/sub/addi by suppressing the register write.
module mips_multicycle_control #(
    parameter bit OVF_TRAP = 1'b1
) (
    input  logic       ck,
    input  logic       reset_,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       overflow,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegDest,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       Branch,
    output logic       PCWrite,
    output logic       ovf_exc,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q, state_d;
    logic   ovf_q, ovf_d;

    logic       funct_addsub;
    logic       funct_legal;
    logic [2:0] alu_funct;

    // ALU decoder for R-type; unknown functions compute an add but never write back.
    always_comb begin
        alu_funct    = ALU_ADD;
        funct_legal  = 1'b1;
        funct_addsub = 1'b0;
        case (Funct)
            FN_ADD: begin
                alu_funct    = ALU_ADD;
                funct_addsub = 1'b1;
            end
            FN_SUB: begin
                alu_funct    = ALU_SUB;
                funct_addsub = 1'b1;
            end
            FN_AND:  alu_funct = ALU_AND;
            FN_OR:   alu_funct = ALU_OR;
            FN_SLT:  alu_funct = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Op == OP_LW)      state_d = S_MEMRD;
                else if (Op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_FETCH;
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Overflow is only meaningful when captured at the end of an arithmetic execute step.
    always_comb begin
        ovf_d = 1'b0;
        if ((state_q == S_EXEC && funct_addsub) || state_q == S_ADDIEX)
            ovf_d = overflow;
    end

    always_ff @(posedge ck or posedge reset_) begin
        if (reset_) begin
            state_q <= S_FETCH;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    logic trap;
    assign trap = OVF_TRAP && ovf_q;

    logic reg_write_raw, mem_write_raw, ir_write_raw, pc_write_raw, branch_raw, ovf_exc_raw;

    always_comb begin
        IorD          = 1'b0;
        RegDest       = 1'b0;
        MemtoReg      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        PCSrc         = 2'b00;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        branch_raw    = 1'b0;
        ovf_exc_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB      = 2'b01;
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWR: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = alu_funct;
            end
            S_ALUWB: begin
                ALUSrcA       = 1'b1;
                ALUControl    = alu_funct;
                RegDest       = 1'b1;
                reg_write_raw = funct_legal && !trap;
                ovf_exc_raw   = trap;
            end
            S_ADDIWB: begin
                reg_write_raw = !trap;
                ovf_exc_raw   = trap;
            end
            S_BEQ: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch_raw = 1'b1;
            end
            S_JUMP: begin
                PCSrc        = 2'b10;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are forced low for as long as reset is held, not just at the edge.
    assign RegWrite = reg_write_raw && !reset_;
    assign MemWrite = mem_write_raw && !reset_;
    assign IRWrite  = ir_write_raw  && !reset_;
    assign PCWrite  = pc_write_raw  && !reset_;
    assign Branch   = branch_raw    && !reset_;
    assign ovf_exc  = ovf_exc_raw   && !reset_;
    assign state    = state_q;

endmodule
